multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle control unit for the MIPS-subset datapath (add, sub, and, or, slt, jr, lw, sw, beq, addi, andi, ori, j, jal). It sequences a shared-memory, multicycle datapath through fetch/decode/execute/memory/writeback states. It stalls on a single-outstanding memory request/ready handshake. ULAControl uses the existing single-cycle encoding (010 add, 110 sub, 000 and, 001 or, 111 slt, 100 idle).

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. The block uses one clock; reset is asynchronous and active-low.
- OP  in  6  opcode from instruction register; stable except on IRWrite.
- Funct  in  6  funct field from instruction register.
- MemReady  in  1  memory accepted/completed the current request this cycle.
- MemReq  out  1  memory access requested.
- IorD  out  1  address source: 0 = PC, 1 = ULAOut.
- MemWrite  out  1  request is a write.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load qualified by datapath Zero.
- PCSrc  out  2  PC source: 00 = ULA result, 01 = ULAOut, 10 = jump target, 11 = register A.
- ULASrcA  out  1  ULA operand A: 0 = PC, 1 = register A.
- ULASrcB  out  2  ULA operand B: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = immediate shifted left by 2.
- ZeroExt  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- ULAControl  out  3  ULA operation.
- RegWrite  out  1  register file write.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback source: 1 = MDR.
- Link  out  1  write PC to register $31.
- Illegal  out  1  one-cycle pulse on an unsupported instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, JR, ILLEGAL.
- Outputs are Moore outputs of the state. The only Mealy terms are IRWrite and PCWrite in FETCH, which are gated by MemReady.
- Every output not listed for a state is 0. ULAControl defaults to 100.
- **FETCH:** MemReq=1, IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00. If MemReady: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
- **DECODE:** ULASrcA=0, ULASrcB=11, ULAControl=010 (branch target goes to ULAOut). Next state:
  - lw/sw → MEMADR
  - R-type with a legal Funct → EXEC_R, except jr (Funct 001000) → JR
  - addi/andi/ori → EXEC_I
  - beq → BRANCH
  - j/jal → JUMP
  - anything else → ILLEGAL
- **MEMADR:** ULASrcA=1, ULASrcB=10, ULAControl=010. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD:** MemReq=1, IorD=1. On MemReady go to MEMWB.
- **MEMWB:** RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- **MEMWR:** MemReq=1, MemWrite=1, IorD=1. On MemReady go to FETCH.
- **EXEC_R:** ULASrcA=1, ULASrcB=00, ULAControl decoded from Funct. Go to ALUWB.
- **EXEC_I:** ULASrcA=1, ULASrcB=10. addi: ULAControl=010. andi: 000 with ZeroExt=1. ori: 001 with ZeroExt=1. Go to ALUWB.
- **ALUWB:** RegWrite=1, RegDst = (OP==0). Go to FETCH.
- **BRANCH:** ULASrcA=1, ULASrcB=00, ULAControl=110, Branch=1, PCSrc=01. Go to FETCH.
- **JUMP:** PCWrite=1, PCSrc=10. For jal (OP 000011) also RegWrite=1 and Link=1; the PC already holds PC+4. Go to FETCH.
- **JR:** PCWrite=1, PCSrc=11. Go to FETCH.
- **ILLEGAL:** Illegal=1 for exactly one cycle. No register or memory write. Go to FETCH.

## Timing
- Reset: while rst_n=0, state=FETCH, every output is 0 and ULAControl=100. The first request is issued in the first cycle after release.
- Latency with MemReady tied to 1, in cycles:
  - beq, j, jal, jr, illegal: 3
  - sw, R-type, I-type: 4
  - lw: 5
- Each wait cycle at MemReady=0 adds one cycle.
- MemReq and the address controls stay constant through the wait. A request completes on the edge where MemReq=1 and MemReady=1.
- MemReady=1 while MemReq=0 is ignored.
- Reset mid-request: MemReq and MemWrite drop combinationally. No write is issued afterward. After release, execution restarts at FETCH with IorD=0.
- OP and Funct are sampled only in DECODE, EXEC_R, EXEC_I, ALUWB and JUMP.

## Structure
- Shared package mips_pkg holds:
  - state enum (4-bit)
  - opcode and funct constants
  - ULAControl codes
  - PCSrc and ULASrcB codes
- One sub-module, ula_decoder: combinational Funct/OP to ULAControl mapping, plus a legal flag used by DECODE.

## Test plan
1. Reset release, addi (OP 001000), MemReady=1 → FETCH, DECODE, EXEC_I, ALUWB. Cycle 4: RegWrite=1, RegDst=0, ULAControl was 010 in cycle 3.
2. lw with MemReady=0 for 3 cycles in MEMRD → MemReq=1 and IorD=1 held. MEMWB has MemtoReg=1. Total 8 cycles.
3. beq → cycle 3: Branch=1, ULAControl=110, PCSrc=01, PCWrite=0.
4. jal → cycle 3: PCWrite=1, PCSrc=10, RegWrite=1, Link=1. Next cycle is FETCH.
5. OP 111111, then R-type with Funct 000000 → each gives an Illegal pulse of 1 cycle in cycle 3, with RegWrite=0 and MemWrite=0 throughout.
6. sw with rst_n asserted during the MEMWR wait → MemWrite=0 and MemReq=0 in the same cycle. After release: FETCH, MemReq=1, IorD=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_JR      = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ULAControl codes
  localparam logic [2:0] ULA_AND  = 3'b000;
  localparam logic [2:0] ULA_OR   = 3'b001;
  localparam logic [2:0] ULA_ADD  = 3'b010;
  localparam logic [2:0] ULA_IDLE = 3'b100;
  localparam logic [2:0] ULA_SUB  = 3'b110;
  localparam logic [2:0] ULA_SLT  = 3'b111;

  // PCSrc codes
  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // ULASrcB codes
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/ula_decoder.sv
// Combinational OP/Funct decode: ULA operation, immediate extension mode,
// and whether the instruction is supported at all.
module ula_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] ula_ctrl,
  output logic       zero_ext,
  output logic       legal
);

  // Map instruction fields to ULA operation and legality
  always_comb begin
    ula_ctrl = ULA_IDLE;
    zero_ext = 1'b0;
    legal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin ula_ctrl = ULA_ADD; legal = 1'b1; end
          FN_SUB: begin ula_ctrl = ULA_SUB; legal = 1'b1; end
          FN_AND: begin ula_ctrl = ULA_AND; legal = 1'b1; end
          FN_OR:  begin ula_ctrl = ULA_OR;  legal = 1'b1; end
          FN_SLT: begin ula_ctrl = ULA_SLT; legal = 1'b1; end
          FN_JR:  legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin ula_ctrl = ULA_ADD; legal = 1'b1; end
      OP_ANDI: begin ula_ctrl = ULA_AND; zero_ext = 1'b1; legal = 1'b1; end
      OP_ORI:  begin ula_ctrl = ULA_OR;  zero_ext = 1'b1; legal = 1'b1; end
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the MIPS-subset datapath with a
// single-outstanding memory request/ready handshake.
module multicycle_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic       ZeroExt,
  output logic [2:0] ULAControl,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Link,
  output logic       Illegal
);

  state_t     state_q, state_d;
  // Remembers sw vs lw from DECODE so MEMADR need not look at OP again
  logic       is_store_q, is_store_d;
  logic [2:0] dec_ula_ctrl;
  logic       dec_zero_ext;
  logic       dec_legal;

  ula_decoder u_ula_decoder (
    .op       (OP),
    .funct    (Funct),
    .ula_ctrl (dec_ula_ctrl),
    .zero_ext (dec_zero_ext),
    .legal    (dec_legal)
  );

  // State and store-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // Next-state and outputs; everything is forced idle while reset is held
  // so a pending request or write drops immediately.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ULA;
    ULASrcA    = 1'b0;
    ULASrcB    = SRCB_REGB;
    ZeroExt    = 1'b0;
    ULAControl = ULA_IDLE;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    Link       = 1'b0;
    Illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemReq     = 1'b1;
          ULASrcB    = SRCB_FOUR;
          ULAControl = ULA_ADD;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          ULASrcB    = SRCB_IMMSH;
          ULAControl = ULA_ADD;
          is_store_d = (OP == OP_SW);
          if (!dec_legal) begin
            state_d = S_ILLEGAL;
          end else begin
            case (OP)
              OP_LW, OP_SW:              state_d = S_MEMADR;
              OP_RTYPE:                  state_d = (Funct == FN_JR) ? S_JR : S_EXEC_R;
              OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
              OP_BEQ:                    state_d = S_BRANCH;
              OP_J, OP_JAL:              state_d = S_JUMP;
              default:                   state_d = S_ILLEGAL;
            endcase
          end
        end
        S_MEMADR: begin
          ULASrcA    = 1'b1;
          ULASrcB    = SRCB_IMM;
          ULAControl = ULA_ADD;
          state_d    = is_store_q ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemReq = 1'b1;
          IorD   = 1'b1;
          if (MemReady) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) state_d = S_FETCH;
        end
        S_EXEC_R: begin
          ULASrcA    = 1'b1;
          ULAControl = dec_ula_ctrl;
          state_d    = S_ALUWB;
        end
        S_EXEC_I: begin
          ULASrcA    = 1'b1;
          ULASrcB    = SRCB_IMM;
          ULAControl = dec_ula_ctrl;
          ZeroExt    = dec_zero_ext;
          state_d    = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = (OP == OP_RTYPE);
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ULASrcA    = 1'b1;
          ULAControl = ULA_SUB;
          Branch     = 1'b1;
          PCSrc      = PCSRC_ULAOUT;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSrc    = PCSRC_JUMP;
          RegWrite = (OP == OP_JAL);
          Link     = (OP == OP_JAL);
          state_d  = S_FETCH;
        end
        S_JR: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_REGA;
          state_d = S_FETCH;
        end
        S_ILLEGAL: begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: expected per-cycle output vectors are queued with the
// stimulus for each instruction and checked one per cycle at the falling edge.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       MemReady;
  logic       MemReq, IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0] PCSrc;
  logic       ULASrcA;
  logic [1:0] ULASrcB;
  logic       ZeroExt;
  logic [2:0] ULAControl;
  logic       RegWrite, RegDst, MemtoReg, Link, Illegal;

  typedef struct packed {
    logic       req;
    logic       iord;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       br;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic       zx;
    logic [2:0] ctl;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       link;
    logic       ill;
  } outs_t;

  typedef struct {
    logic  rdy;
    logic  rst;
    string tag;
  } stim_t;

  outs_t obs;
  outs_t exp_q[$];
  stim_t stim_q[$];
  int    errors = 0;
  int    checks = 0;

  assign obs = '{req: MemReq, iord: IorD, mwr: MemWrite, irw: IRWrite,
                 pcw: PCWrite, br: Branch, pcsrc: PCSrc, srca: ULASrcA,
                 srcb: ULASrcB, zx: ZeroExt, ctl: ULAControl, rw: RegWrite,
                 rdst: RegDst, m2r: MemtoReg, link: Link, ill: Illegal};

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ULASrcA(ULASrcA),
    .ULASrcB(ULASrcB), .ZeroExt(ZeroExt), .ULAControl(ULAControl),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Link(Link),
    .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors for each state, written from the state table
  function automatic outs_t e_idle();
    outs_t o = '0;
    o.ctl = 3'b100;
    return o;
  endfunction
  function automatic outs_t e_fetch(input logic rdy);
    outs_t o = e_idle();
    o.req = 1'b1; o.srcb = 2'b01; o.ctl = 3'b010; o.irw = rdy; o.pcw = rdy;
    return o;
  endfunction
  function automatic outs_t e_decode();
    outs_t o = e_idle();
    o.srcb = 2'b11; o.ctl = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_memadr();
    outs_t o = e_idle();
    o.srca = 1'b1; o.srcb = 2'b10; o.ctl = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_mem(input logic wr);
    outs_t o = e_idle();
    o.req = 1'b1; o.iord = 1'b1; o.mwr = wr;
    return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = e_idle();
    o.rw = 1'b1; o.m2r = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_exec(input logic [1:0] srcb, input logic [2:0] ctl, input logic zx);
    outs_t o = e_idle();
    o.srca = 1'b1; o.srcb = srcb; o.ctl = ctl; o.zx = zx;
    return o;
  endfunction
  function automatic outs_t e_aluwb(input logic rd);
    outs_t o = e_idle();
    o.rw = 1'b1; o.rdst = rd;
    return o;
  endfunction
  function automatic outs_t e_branch();
    outs_t o = e_idle();
    o.srca = 1'b1; o.ctl = 3'b110; o.br = 1'b1; o.pcsrc = 2'b01;
    return o;
  endfunction
  function automatic outs_t e_jump(input logic lnk);
    outs_t o = e_idle();
    o.pcw = 1'b1; o.pcsrc = 2'b10; o.rw = lnk; o.link = lnk;
    return o;
  endfunction
  function automatic outs_t e_jr();
    outs_t o = e_idle();
    o.pcw = 1'b1; o.pcsrc = 2'b11;
    return o;
  endfunction
  function automatic outs_t e_illegal();
    outs_t o = e_idle();
    o.ill = 1'b1;
    return o;
  endfunction

  task automatic push(input outs_t e, input logic rdy, input logic rst, input string tag);
    stim_t s;
    s.rdy = rdy; s.rst = rst; s.tag = tag;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Drive one cycle's inputs just after the falling edge, check, advance
  task automatic run_cycle();
    stim_t s;
    outs_t e;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    rst_n    = s.rst;
    MemReady = s.rdy;
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s op=%b funct=%b observed=%h expected=%h", s.tag, OP, Funct, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0) begin
      run_cycle();
      n++;
    end
    $display("instr %s op=%b funct=%b cycles=%0d errors=%0d", name, OP, Funct, n, errors);
  endtask

  // Queue the full expected cycle sequence of one instruction, then run it
  task automatic instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int mw);
    OP = op;
    Funct = fn;
    for (int i = 0; i < fw; i++) push(e_fetch(1'b0), 1'b0, 1'b1, "fetch_wait");
    push(e_fetch(1'b1), 1'b1, 1'b1, "fetch");
    push(e_decode(), 1'b1, 1'b1, "decode");
    case (op)
      6'b100011: begin
        push(e_memadr(), 1'b1, 1'b1, "memadr");
        for (int i = 0; i < mw; i++) push(e_mem(1'b0), 1'b0, 1'b1, "memrd_wait");
        push(e_mem(1'b0), 1'b1, 1'b1, "memrd");
        push(e_memwb(), 1'b1, 1'b1, "memwb");
      end
      6'b101011: begin
        push(e_memadr(), 1'b1, 1'b1, "memadr");
        for (int i = 0; i < mw; i++) push(e_mem(1'b1), 1'b0, 1'b1, "memwr_wait");
        push(e_mem(1'b1), 1'b1, 1'b1, "memwr");
      end
      6'b000000: begin
        case (fn)
          6'b100000: begin push(e_exec(2'b00, 3'b010, 1'b0), 1'b1, 1'b1, "exec_add"); push(e_aluwb(1'b1), 1'b1, 1'b1, "aluwb_r"); end
          6'b100010: begin push(e_exec(2'b00, 3'b110, 1'b0), 1'b1, 1'b1, "exec_sub"); push(e_aluwb(1'b1), 1'b1, 1'b1, "aluwb_r"); end
          6'b100100: begin push(e_exec(2'b00, 3'b000, 1'b0), 1'b1, 1'b1, "exec_and"); push(e_aluwb(1'b1), 1'b1, 1'b1, "aluwb_r"); end
          6'b100101: begin push(e_exec(2'b00, 3'b001, 1'b0), 1'b1, 1'b1, "exec_or");  push(e_aluwb(1'b1), 1'b1, 1'b1, "aluwb_r"); end
          6'b101010: begin push(e_exec(2'b00, 3'b111, 1'b0), 1'b1, 1'b1, "exec_slt"); push(e_aluwb(1'b1), 1'b1, 1'b1, "aluwb_r"); end
          6'b001000: push(e_jr(), 1'b1, 1'b1, "jr");
          default:   push(e_illegal(), 1'b1, 1'b1, "illegal_funct");
        endcase
      end
      6'b001000: begin push(e_exec(2'b10, 3'b010, 1'b0), 1'b1, 1'b1, "exec_addi"); push(e_aluwb(1'b0), 1'b1, 1'b1, "aluwb_i"); end
      6'b001100: begin push(e_exec(2'b10, 3'b000, 1'b1), 1'b1, 1'b1, "exec_andi"); push(e_aluwb(1'b0), 1'b1, 1'b1, "aluwb_i"); end
      6'b001101: begin push(e_exec(2'b10, 3'b001, 1'b1), 1'b1, 1'b1, "exec_ori");  push(e_aluwb(1'b0), 1'b1, 1'b1, "aluwb_i"); end
      6'b000100: push(e_branch(), 1'b1, 1'b1, "branch");
      6'b000010: push(e_jump(1'b0), 1'b1, 1'b1, "jump");
      6'b000011: push(e_jump(1'b1), 1'b1, 1'b1, "jal");
      default:   push(e_illegal(), 1'b1, 1'b1, "illegal_op");
    endcase
    drain(name);
  endtask

  initial begin
    rst_n    = 1'b0;
    MemReady = 1'b1;
    OP       = 6'b000000;
    Funct    = 6'b000000;
    @(negedge clk);

    // Held in reset: all outputs idle even with MemReady high
    push(e_idle(), 1'b1, 1'b0, "reset");
    push(e_idle(), 1'b1, 1'b0, "reset");
    drain("reset");

    instr("addi", 6'b001000, 6'b000000, 0, 0);
    instr("lw_wait3", 6'b100011, 6'b000000, 0, 3);
    instr("beq", 6'b000100, 6'b000000, 0, 0);
    instr("jal", 6'b000011, 6'b000000, 0, 0);
    instr("bad_op", 6'b111111, 6'b000000, 0, 0);
    instr("bad_funct", 6'b000000, 6'b000000, 0, 0);
    instr("add", 6'b000000, 6'b100000, 0, 0);
    instr("sub", 6'b000000, 6'b100010, 1, 0);
    instr("and", 6'b000000, 6'b100100, 0, 0);
    instr("or", 6'b000000, 6'b100101, 0, 0);
    instr("slt", 6'b000000, 6'b101010, 0, 0);
    instr("jr", 6'b000000, 6'b001000, 0, 0);
    instr("j", 6'b000010, 6'b000000, 0, 0);
    instr("andi", 6'b001100, 6'b000000, 0, 0);
    instr("ori", 6'b001101, 6'b000000, 0, 0);
    instr("sw_wait1", 6'b101011, 6'b000000, 0, 1);
    instr("lw_fwait2", 6'b100011, 6'b000000, 2, 0);

    // sw interrupted by reset during the write wait
    OP = 6'b101011;
    Funct = 6'b000000;
    push(e_fetch(1'b1), 1'b1, 1'b1, "rst_sw_fetch");
    push(e_decode(), 1'b1, 1'b1, "rst_sw_decode");
    push(e_memadr(), 1'b1, 1'b1, "rst_sw_memadr");
    push(e_mem(1'b1), 1'b0, 1'b1, "rst_sw_memwr_wait");
    push(e_mem(1'b1), 1'b0, 1'b1, "rst_sw_memwr_wait");
    push(e_idle(), 1'b1, 1'b0, "rst_mid_write");
    push(e_idle(), 1'b1, 1'b0, "rst_mid_write_hold");
    push(e_fetch(1'b0), 1'b0, 1'b1, "refetch_wait");
    push(e_fetch(1'b1), 1'b1, 1'b1, "refetch");
    push(e_decode(), 1'b1, 1'b1, "rst_sw2_decode");
    push(e_memadr(), 1'b1, 1'b1, "rst_sw2_memadr");
    push(e_mem(1'b1), 1'b1, 1'b1, "rst_sw2_memwr");
    push(e_fetch(1'b0), 1'b0, 1'b1, "final_fetch");
    drain("sw_reset_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
